ram_bus_arbiter: RTL
====================

# ram_bus_arbiter

Three-port arbiter that shares the single-port main memory (20-bit address, 8-bit data, one-cycle synchronous read) among the video fetch, the CPU and the serial loader/DMA. It sits between the requesters and the main memory block in the board top-level and runs in the bus clock domain. It registers one memory command per cycle and routes returned read data back to the issuing port with a fixed latency. Port 0 has fixed highest priority. Ports 1 and 2 share the remaining slots round-robin.

## Interface
Parameters:
- ADDR_W, 20, memory address width
- DATA_W, 8, memory data width
- STARVE_LIMIT, 8, consecutive port-0 grants allowed before a pending port 1/2 is forced in (used only with ARB_STARVE_GUARD_EN)

Ports (clock and reset first; `pN_` lines apply to N = 0, 1, 2):
- bus_clk  in  1  bus clock; every register is clocked on its rising edge
- bus_reset_n  in  1  reset, synchronous and active-low
- pN_req  in  1  request; a high value sampled at an edge is one request
- pN_we  in  1  1 = write, 0 = read; qualified by pN_req
- pN_addr  in  ADDR_W  request address
- pN_wdata  in  DATA_W  write data
- pN_ack  out  1  one-cycle pulse; the request was issued to memory
- pN_rvalid  out  1  one-cycle pulse; pN_rdata holds read data
- pN_rdata  out  DATA_W  read data; holds its last value between pulses
- mem_ena  out  1  memory enable
- mem_we  out  1  memory write strobe; high only while mem_ena is high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the cycle after a read command
- mem_owner  out  2  port owning the current command (0–2); 3 = idle

## Operation
- At each edge E the block samples all requests and selects at most one winner:
  - p0 wins whenever p0_req is high.
  - Otherwise p1 or p2 wins. If both are requesting, the port not granted last wins.
- rr_last records the last p1/p2 grant.
  - It updates only on a p1 or p2 grant.
  - Reset value is 2, so p1 wins the first tie.
- On a grant at edge E, for the cycle after E:
  - mem_ena = 1, and mem_we, mem_addr and mem_wdata are loaded from the winning port.
  - mem_owner = winner index.
  - pN_ack = 1 for the winner.
- With no request:
  - mem_ena = 0, mem_we = 0, mem_owner = 3.
  - mem_addr and mem_wdata hold their previous values.
- Requester rules:
  - Hold pN_we, pN_addr and pN_wdata stable while pN_req is high and the request is not yet acked.
  - pN_req still high in the cycle pN_ack is high counts as a new, back-to-back request.
- Read return:
  - A 2-stage tag pipeline tracks {valid, port} per issued command.
  - For a read granted at edge E, mem_rdata is captured at E+2 into pN_rdata, and pN_rvalid is high for the cycle after E+2.
  - Writes produce no rvalid.
- Losing ports wait indefinitely. No request is ever dropped or reordered within a port.

## Timing
- Reset (bus_reset_n low at an edge):
  - mem_ena = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_owner = 3.
  - All pN_ack = 0, pN_rvalid = 0, pN_rdata = 0.
  - Tag pipeline cleared, rr_last = 2, starve counter = 0.
- Reset mid-operation: in-flight reads are discarded. No rvalid is produced for them after reset is released.
- Latency, request edge to ack: 1 cycle. Request edge to rdata/rvalid: 2 edges, so rvalid is visible 2 cycles after ack.
- Throughput: one command per cycle. Back-to-back reads from different ports return in issue order, one per cycle.
- Simultaneous requests: three-way requests grant p0. With p0 continuously requesting, p1 and p2 are starved unless the guard below is compiled in.
- Single-port continuous request: granted every cycle. rr_last still alternates correctly once the other port joins.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each p0 grant while p1_req or p2_req is high.
  - When the counter equals STARVE_LIMIT, the next grant goes to the round-robin winner of p1/p2 even if p0_req is high.
  - The counter clears on any p1/p2 grant, and whenever neither p1 nor p2 is requesting.
  - Counter width is clog2(STARVE_LIMIT+1).
- ARB_STARVE_GUARD_EN undefined: strict priority. No counter is built, and STARVE_LIMIT is ignored.

## Test plan
- Reset, then p1 reads 0x00010 (memory preloaded with 0x5A) → p1_ack one cycle after the request edge, p1_rvalid two cycles later with p1_rdata = 0x5A, mem_owner = 1 then 3.
- p1 and p2 request continuously (writes to 0x00100 and 0x00200) → grants alternate p1, p2, p1, … and mem_we is never high while mem_ena is low.
- p0, p1 and p2 all request one read in the same cycle → acks in order p0, p1, p2 on consecutive cycles; rvalids follow in the same order with each port's data.
- p0 requests continuously for 20 cycles while p1 is pending:
  - With ARB_STARVE_GUARD_EN: p1 is granted after exactly 8 p0 grants.
  - Without it: p1 is not granted until p0 drops.
- Read issued, then bus_reset_n held low one cycle at the ack cycle → no p*_rvalid afterwards, all outputs at reset values, the next request behaves as after power-up.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one single-port synchronous-read memory among three requesters.
// Port 0 has fixed priority; ports 1 and 2 alternate round-robin. Read data returns to the
// issuing port through a 2-stage {valid, port} tag pipeline.
// Optional build macro ARB_STARVE_GUARD_EN adds a counter that forces a pending port 1/2 in
// after STARVE_LIMIT consecutive port-0 grants.
module ram_bus_arbiter #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              bus_clk,
    input  logic              bus_reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic              p2_ack,
    output logic              p2_rvalid,
    output logic [DATA_W-1:0] p2_rdata,
    output logic              mem_ena,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_owner
);

    logic              w_any12;
    logic              w_force;
    logic              w_grant;
    logic [1:0]        w_rr_pick;
    logic [1:0]        w_win;
    logic [2:0]        w_ack_d;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_mem_ena;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_mem_owner;
    logic [1:0]        r_rr_last;
    logic [2:0]        r_ack;
    logic [2:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata [3];
    logic              r_tag1_v;
    logic [1:0]        r_tag1_port;
    logic              r_tag2_v;
    logic [1:0]        r_tag2_port;

    // Winner selection and command mux for the current edge
    always_comb begin
        w_any12 = p1_req | p2_req;
        if (p1_req && p2_req) begin
            w_rr_pick = (r_rr_last == 2'd1) ? 2'd2 : 2'd1;
        end else if (p1_req) begin
            w_rr_pick = 2'd1;
        end else begin
            w_rr_pick = 2'd2;
        end

        w_grant = 1'b1;
        w_win   = 2'd3;
        if (p0_req && !w_force) begin
            w_win = 2'd0;
        end else if (w_any12) begin
            w_win = w_rr_pick;
        end else begin
            w_grant = 1'b0;
        end

        w_ack_d     = 3'b000;
        w_sel_we    = p0_we;
        w_sel_addr  = p0_addr;
        w_sel_wdata = p0_wdata;
        case (w_win)
            2'd0: begin
                w_ack_d = 3'b001;
            end
            2'd1: begin
                w_ack_d     = 3'b010;
                w_sel_we    = p1_we;
                w_sel_addr  = p1_addr;
                w_sel_wdata = p1_wdata;
            end
            2'd2: begin
                w_ack_d     = 3'b100;
                w_sel_we    = p2_we;
                w_sel_addr  = p2_addr;
                w_sel_wdata = p2_wdata;
            end
            default: w_ack_d = 3'b000;
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force = w_any12 && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count consecutive port-0 grants that bypass a waiting port 1/2
    always_ff @(posedge bus_clk) begin
        if (!bus_reset_n) begin
            r_starve_cnt <= '0;
        end else if (!w_any12 || (w_grant && w_win != 2'd0)) begin
            r_starve_cnt <= '0;
        end else if (w_grant && w_win == 2'd0) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Register the memory command, acks, round-robin state and read-return path
    always_ff @(posedge bus_clk) begin
        if (!bus_reset_n) begin
            r_mem_ena   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_owner <= 2'd3;
            r_rr_last   <= 2'd2;
            r_ack       <= 3'b000;
            r_rvalid    <= 3'b000;
            r_tag1_v    <= 1'b0;
            r_tag1_port <= 2'd0;
            r_tag2_v    <= 1'b0;
            r_tag2_port <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_mem_ena   <= w_grant;
            r_mem_we    <= w_grant & w_sel_we;
            r_mem_owner <= w_win;
            r_ack       <= w_ack_d;
            if (w_grant) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
            if (w_grant && w_win != 2'd0) begin
                r_rr_last <= w_win;
            end

            // Tag stage 1 matches the command cycle; stage 2 matches the data cycle
            r_tag1_v    <= w_grant & ~w_sel_we;
            r_tag1_port <= w_win;
            r_tag2_v    <= r_tag1_v;
            r_tag2_port <= r_tag1_port;

            r_rvalid <= 3'b000;
            if (r_tag2_v) begin
                case (r_tag2_port)
                    2'd0: begin
                        r_rvalid[0] <= 1'b1;
                        r_rdata[0]  <= mem_rdata;
                    end
                    2'd1: begin
                        r_rvalid[1] <= 1'b1;
                        r_rdata[1]  <= mem_rdata;
                    end
                    2'd2: begin
                        r_rvalid[2] <= 1'b1;
                        r_rdata[2]  <= mem_rdata;
                    end
                    default: r_rvalid <= 3'b000;
                endcase
            end
        end
    end

    assign mem_ena   = r_mem_ena;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_owner = r_mem_owner;
    assign p0_ack    = r_ack[0];
    assign p1_ack    = r_ack[1];
    assign p2_ack    = r_ack[2];
    assign p0_rvalid = r_rvalid[0];
    assign p1_rvalid = r_rvalid[1];
    assign p2_rvalid = r_rvalid[2];
    assign p0_rdata  = r_rdata[0];
    assign p1_rdata  = r_rdata[1];
    assign p2_rdata  = r_rdata[2];

endmodule
